// File: rtl/timer_sched_ctrl.sv
// Shares one hardware timer among NUM_REQ requesters.
// Round-robin grant, start/ack/run sequencing, completion report.
module timer_sched_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int TIMER_WIDTH = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TIMER_WIDTH-1:0] req_load,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             cancel,
  input  logic                           hold,
  output logic [TIMER_WIDTH-1:0]         tmr_load,
  output logic                           tmr_start,
  output logic                           tmr_stop,
  output logic                           tmr_pause,
  input  logic [TIMER_WIDTH-1:0]         tmr_value,
  input  logic                           tmr_overflow,
  input  logic                           tmr_match,
  input  logic                           tmr_active,
  output logic                           done_valid,
  input  logic                           done_ready,
  output logic [$clog2(NUM_REQ)-1:0]     done_id,
  output logic [1:0]                     done_status,
  output logic [TIMER_WIDTH-1:0]         done_value,
  output logic                           busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int IW  = IDW + 1;
  localparam int CW  = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, START, ACK, RUN, DONE
  } state_t;

  state_t state, state_n;

  logic [IDW-1:0]         last_grant, last_grant_n;
  logic [IDW-1:0]         owner, owner_n;
  logic [CW-1:0]          ack_cnt, ack_cnt_n;
  logic [NUM_REQ-1:0]     req_ready_n;
  logic [TIMER_WIDTH-1:0] tmr_load_n;
  logic                   start_n, stop_n, pause_n;
  logic                   done_valid_n;
  logic [IDW-1:0]         done_id_n;
  logic [1:0]             done_status_n;
  logic [TIMER_WIDTH-1:0] done_value_n;
  logic                   fin;
  logic [1:0]             fin_status;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IW-1:0]  cand;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'(last_grant) + IW'(k);
      if (cand >= IW'(NUM_REQ))
        cand = cand - IW'(NUM_REQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    owner_n       = owner;
    ack_cnt_n     = ack_cnt;
    req_ready_n   = '0;
    tmr_load_n    = tmr_load;
    start_n       = 1'b0;
    stop_n        = 1'b0;
    pause_n       = 1'b0;
    done_valid_n  = done_valid;
    done_id_n     = done_id;
    done_status_n = done_status;
    done_value_n  = done_value;
    fin           = 1'b0;
    fin_status    = 2'b00;
    unique case (state)
      IDLE: begin
        if (gnt_found && !tmr_active) begin
          req_ready_n[gnt_idx] = 1'b1;
          tmr_load_n = req_load[int'(gnt_idx)*TIMER_WIDTH +: TIMER_WIDTH];
          owner_n      = gnt_idx;
          last_grant_n = gnt_idx;
          start_n      = 1'b1;
          state_n      = START;
        end
      end
      START: begin
        ack_cnt_n = '0;
        state_n   = ACK;
      end
      ACK: begin
        if (tmr_active) begin
          state_n = RUN;
        end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
          fin        = 1'b1;
          fin_status = 2'b11;
          stop_n     = 1'b1;
        end else begin
          ack_cnt_n = ack_cnt + 1'b1;
        end
      end
      RUN: begin
        pause_n = hold;
        if (cancel[owner]) begin
          fin        = 1'b1;
          fin_status = 2'b10;
          stop_n     = 1'b1;
        end else if (tmr_overflow) begin
          // Timer has already halted itself; no stop needed.
          fin        = 1'b1;
          fin_status = 2'b01;
        end else if (tmr_match) begin
          fin        = 1'b1;
          fin_status = 2'b00;
          stop_n     = 1'b1;
        end
      end
      DONE: begin
        if (done_ready) begin
          done_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (fin) begin
      state_n       = DONE;
      done_valid_n  = 1'b1;
      done_id_n     = owner;
      done_status_n = fin_status;
      done_value_n  = tmr_value;
      pause_n       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IDW'(NUM_REQ - 1);
      owner       <= '0;
      ack_cnt     <= '0;
      req_ready   <= '0;
      tmr_load    <= '0;
      tmr_start   <= 1'b0;
      tmr_stop    <= 1'b0;
      tmr_pause   <= 1'b0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_status <= 2'b00;
      done_value  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      owner       <= owner_n;
      ack_cnt     <= ack_cnt_n;
      req_ready   <= req_ready_n;
      tmr_load    <= tmr_load_n;
      tmr_start   <= start_n;
      tmr_stop    <= stop_n;
      tmr_pause   <= pause_n;
      done_valid  <= done_valid_n;
      done_id     <= done_id_n;
      done_status <= done_status_n;
      done_value  <= done_value_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Randomized bench for timer_sched_ctrl.
// Bench drives the timer side and predicts grants/status itself.
module tb_timer_sched_ctrl;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_load = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   cancel = '0;
  logic           hold = 1'b0;
  logic [W-1:0]   tmr_load;
  logic           tmr_start, tmr_stop, tmr_pause;
  logic [W-1:0]   tmr_value = '0;
  logic           tmr_overflow = 1'b0;
  logic           tmr_match = 1'b0;
  logic           tmr_active = 1'b0;
  logic           done_valid;
  logic           done_ready = 1'b0;
  logic [1:0]     done_id;
  logic [1:0]     done_status;
  logic [W-1:0]   done_value;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int stop_cnt = 0;
  int cyc = 0;
  int last_start = 0;
  int prev_start = 0;
  int last_g = N - 1;
  logic start_d = 1'b0;
  logic stop_d = 1'b0;

  timer_sched_ctrl #(
    .NUM_REQ(N), .TIMER_WIDTH(W), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_load(req_load),
    .req_ready(req_ready), .cancel(cancel), .hold(hold),
    .tmr_load(tmr_load), .tmr_start(tmr_start),
    .tmr_stop(tmr_stop), .tmr_pause(tmr_pause),
    .tmr_value(tmr_value), .tmr_overflow(tmr_overflow),
    .tmr_match(tmr_match), .tmr_active(tmr_active),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_id(done_id), .done_status(done_status),
    .done_value(done_value), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tmr_stop) stop_cnt++;
      if (tmr_start) begin
        prev_start = last_start;
        last_start = cyc;
      end
      if (tmr_start || tmr_stop) begin
        checks++;
        if ((tmr_start && tmr_stop) || (tmr_start && start_d) ||
            (tmr_stop && stop_d)) begin
          failures++;
          $display("FAIL pulse: start=%b stop=%b prev_start=%b prev_stop=%b",
                   tmr_start, tmr_stop, start_d, stop_d);
        end
      end
      start_d = tmr_start;
      stop_d  = tmr_stop;
    end else begin
      start_d = 1'b0;
      stop_d  = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tmr_value = $urandom;
  endtask

  task automatic apply_reset();
    tmr_active = 1'b0;
    req_valid  = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    last_g = N - 1;
    tick();
  endtask

  // One complete job; expected grant comes from a round-robin model.
  // ack_dly < 0 means the timer never acknowledges.
  // ev = {cancel owner, overflow, match} fired together in one RUN cycle.
  task automatic do_job(input logic [N-1:0] vld, input int ack_dly,
                        input int hold_len, input logic [2:0] ev,
                        input int rdy_dly);
    int g, n, nl, stops0;
    logic [W-1:0] exp_ld, pv;
    logic [1:0] exp_st;
    logic exp_stop;
    logic [N-1:0] own;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && vld[(last_g + k) % N]) g = (last_g + k) % N;
    last_g = g;
    own = '0;
    own[g] = 1'b1;
    req_load = {$urandom, $urandom, $urandom, $urandom};
    exp_ld = req_load[g*W +: W];
    if (ack_dly < 0) exp_st = 2'b11;
    else if (ev[2]) exp_st = 2'b10;
    else if (ev[1]) exp_st = 2'b01;
    else exp_st = 2'b00;
    exp_stop = (exp_st != 2'b01);
    stops0 = stop_cnt;
    pv = '0;
    req_valid = vld;
    n = 0;
    do begin tick(); n++; end while (req_ready == '0 && n < 20);
    checks++;
    if (req_ready !== own || tmr_start !== 1'b1 ||
        tmr_load !== exp_ld || busy !== 1'b1) begin
      failures++;
      $display("FAIL grant: ready=%b start=%b load=%h busy=%b want ready=%b start=1 load=%h busy=1",
               req_ready, tmr_start, tmr_load, busy, own, exp_ld);
      req_valid = '0;
      return;
    end
    if (ack_dly >= 0) begin
      for (int i = 0; i <= ack_dly; i++) tick();
      tmr_active = 1'b1;
      tick();
      nl = (hold_len > 0) ? hold_len + 1 : 0;
      for (int j = 0; j < nl; j++) begin
        hold = (j < hold_len);
        cancel = N'($urandom) & ~own;
        tick();
        checks++;
        if (tmr_pause !== (j < hold_len) || done_valid !== 1'b0) begin
          failures++;
          $display("FAIL pause: cycle=%0d pause=%b done_valid=%b want pause=%b done_valid=0",
                   j, tmr_pause, done_valid, (j < hold_len));
        end
      end
      hold = 1'b0;
      cancel = (N'($urandom) & ~own) | (ev[2] ? own : '0);
      tmr_overflow = ev[1];
      tmr_match = ev[0];
    end
    n = 0;
    do begin
      pv = tmr_value;
      tick();
      cancel = '0;
      tmr_overflow = 1'b0;
      tmr_match = 1'b0;
      n++;
    end while (!done_valid && n < 40);
    tmr_active = 1'b0;
    if (ack_dly < 0) begin
      checks++;
      if (n !== TO + 1) begin
        failures++;
        $display("FAIL ack_timeout: cycles start->done=%0d want %0d", n, TO + 1);
      end
    end
    checks++;
    if (done_valid !== 1'b1 || done_id !== 2'(g) || done_status !== exp_st ||
        done_value !== pv || tmr_stop !== exp_stop || tmr_pause !== 1'b0) begin
      failures++;
      $display("FAIL done: v=%b id=%0d st=%b val=%h stop=%b pause=%b want v=1 id=%0d st=%b val=%h stop=%b pause=0",
               done_valid, done_id, done_status, done_value, tmr_stop,
               tmr_pause, g, exp_st, pv, exp_stop);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      checks++;
      if (done_valid !== 1'b1 || done_id !== 2'(g) || done_status !== exp_st ||
          done_value !== pv || req_ready !== '0 || tmr_stop !== 1'b0 ||
          busy !== 1'b1) begin
        failures++;
        $display("FAIL stall: v=%b id=%0d st=%b val=%h ready=%b stop=%b busy=%b want v=1 id=%0d st=%b val=%h ready=0 stop=0 busy=1",
                 done_valid, done_id, done_status, done_value, req_ready,
                 tmr_stop, busy, g, exp_st, pv);
      end
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    checks++;
    if (done_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL handshake: done_valid=%b busy=%b want 0 0", done_valid, busy);
    end
    checks++;
    if (stop_cnt - stops0 !== int'(exp_stop)) begin
      failures++;
      $display("FAIL stop_count: got %0d want %0d", stop_cnt - stops0, int'(exp_stop));
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({req_ready, tmr_start, tmr_stop, tmr_pause, done_valid, busy,
         done_id, done_status, done_value, tmr_load} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b busy=%b dv=%b load=%h want all 0",
               req_ready, busy, done_valid, tmr_load);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b ready=%b want 0 0", busy, req_ready);
    end
  endtask

  task automatic test_active_block();
    logic ok;
    ok = 1'b1;
    tmr_active = 1'b1;
    req_valid = '1;
    repeat (6) begin
      tick();
      if (req_ready !== '0 || busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL active_block: granted while timer active ready=%b busy=%b want 0 0",
               req_ready, busy);
    end
    tmr_active = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_basic();
    do_job(4'b0101, 1, 0, 3'b001, 0);
    do_job(4'b0101, 0, 0, 3'b001, 1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 5; i++)
      do_job(4'b1111, i % 3, 0, 3'b001, 0);
  endtask

  task automatic test_cancel_priority();
    do_job(4'b0010, 2, 0, 3'b110, 0);
  endtask

  task automatic test_timeout();
    do_job(4'b1111, -1, 0, 3'b000, 0);
  endtask

  task automatic test_hold();
    do_job(4'b1001, 0, 10, 3'b010, 0);
  endtask

  task automatic test_done_stall();
    do_job(4'b1111, 3, 0, 3'b101, 20);
  endtask

  task automatic test_back_to_back();
    do_job(4'b1111, 0, 0, 3'b001, 0);
    do_job(4'b1111, 0, 0, 3'b001, 0);
    checks++;
    if (last_start - prev_start !== 5) begin
      failures++;
      $display("FAIL spacing: grant-to-grant=%0d want 5", last_start - prev_start);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    int ad;
    for (int i = 0; i < 40; i++) begin
      v = N'($urandom_range(1, 15));
      ad = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 6));
      do_job(v, ad, int'($urandom_range(0, 4)),
             3'($urandom_range(1, 7)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_job();
    int n, stops0;
    logic ok;
    apply_reset();
    req_valid = 4'b0100;
    n = 0;
    do begin tick(); n++; end while (req_ready == '0 && n < 20);
    tick();
    tmr_active = 1'b1;
    repeat (2) tick();
    stops0 = stop_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, tmr_start, tmr_stop, tmr_pause, done_valid, busy,
         done_id, done_status, done_value, tmr_load} !== '0) begin
      failures++;
      $display("FAIL midjob_reset: ready=%b busy=%b dv=%b stop=%b want all 0",
               req_ready, busy, done_valid, tmr_stop);
    end
    last_g = N - 1;
    repeat (2) tick();
    req_valid = '1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      tick();
      if (req_ready !== '0 || busy !== 1'b0 || done_valid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1 || stop_cnt !== stops0) begin
      failures++;
      $display("FAIL post_reset: ok=%b stops=%0d want ok=1 stops=%0d",
               ok, stop_cnt, stops0);
    end
    tmr_active = 1'b0;
    req_valid = '0;
    do_job(4'b1111, 0, 0, 3'b001, 0);
  endtask

  initial begin
    test_reset();
    test_active_block();
    test_basic();
    test_round_robin();
    test_cancel_priority();
    test_timeout();
    test_hold();
    test_done_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
